if_fetch: RTL and testbench

Instruction fetch unit sitting between the PC register and the instruction bus. It takes the current PC, issues word-aligned fetch requests, and tracks up to `DEPTH` outstanding requests with their PCs. It buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake. It drives the PC register's advance/stall decision and discards in-flight fetches on a pipeline flush.

---
 rtl/if_fetch.sv | 124 ++++++++++++
 tb/tb_if_fetch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch unit: issues word-aligned bus requests under a credit limit,
// tags them with their PC, and buffers returned instructions for decode.
module if_fetch #(
  parameter int CPU_WIDTH = 32,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 jtag_reset_flag_i,
  input  logic [CPU_WIDTH-1:0] pc_i,
  input  logic                 flush_i,
  output logic                 pc_advance_o,
  output logic                 pc_stall_o,
  output logic                 ibus_req_o,
  output logic [CPU_WIDTH-1:0] ibus_addr_o,
  input  logic                 ibus_gnt_i,
  input  logic                 ibus_rvalid_i,
  input  logic [CPU_WIDTH-1:0] ibus_rdata_i,
  output logic                 inst_valid_o,
  output logic [CPU_WIDTH-1:0] inst_o,
  output logic [CPU_WIDTH-1:0] inst_pc_o,
  input  logic                 inst_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [CW-1:0]        out_cnt, disc_cnt, fifo_cnt;
  logic [AW-1:0]        tag_wr, tag_rd, fifo_wr, fifo_rd;
  logic [CPU_WIDTH-1:0] tag_mem  [DEPTH];
  logic [CPU_WIDTH-1:0] pc_mem   [DEPTH];
  logic [CPU_WIDTH-1:0] data_mem [DEPTH];
  logic [CW:0]          credit_used;
  logic                 grant, resp, drop, push, pop;
  logic                 unused_pc_lsb;

  // Credit counts registered state only, so a decode pop frees a slot one cycle later.
  assign credit_used   = {1'b0, out_cnt} + {1'b0, fifo_cnt};
  assign ibus_req_o    = ~flush_i & (credit_used < DEPTH_C);
  assign ibus_addr_o   = {pc_i[CPU_WIDTH-1:2], 2'b00};
  assign unused_pc_lsb = ^pc_i[1:0];

  assign grant        = ibus_req_o & ibus_gnt_i;
  assign pc_advance_o = grant;
  assign pc_stall_o   = ~pc_advance_o & ~flush_i;

  assign resp = ibus_rvalid_i;
  assign drop = resp & (disc_cnt != '0);
  assign push = resp & ~drop & ~flush_i;

  // Decode handshake: the head transfers on a cycle where inst_valid_o and
  // inst_ready_i are both high; while valid and not ready the head holds.
  assign inst_valid_o = (fifo_cnt != '0);
  assign inst_o       = data_mem[fifo_rd];
  assign inst_pc_o    = pc_mem[fifo_rd];
  assign pop          = inst_valid_o & inst_ready_i & ~flush_i;

  always_ff @(posedge clk) begin
    if (grant) tag_mem[tag_wr] <= ibus_addr_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr   <= '0;
      tag_rd   <= '0;
      out_cnt  <= '0;
      disc_cnt <= '0;
    end else if (jtag_reset_flag_i) begin
      tag_wr   <= '0;
      tag_rd   <= '0;
      out_cnt  <= '0;
      disc_cnt <= '0;
    end else begin
      if (grant) tag_wr <= tag_wr + AW'(1);
      if (resp)  tag_rd <= tag_rd + AW'(1);
      case ({grant, resp})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: ;
      endcase
      // Everything still outstanding after a flush belongs to the old stream.
      if (flush_i)   disc_cnt <= out_cnt - CW'(resp);
      else if (drop) disc_cnt <= disc_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (jtag_reset_flag_i) begin
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else if (flush_i) begin
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        pc_mem[fifo_wr]   <= tag_mem[tag_rd];
        data_mem[fifo_wr] <= ibus_rdata_i;
        fifo_wr           <= fifo_wr + AW'(1);
      end
      if (pop) fifo_rd <= fifo_rd + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: bench-side PC register, in-order bus model and
// scoreboard of expected {pc, instr} pairs checked by an independent monitor.
module tb_if_fetch;
  localparam int W     = 32;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         jtag_reset_flag_i;
  logic [W-1:0] pc_i;
  logic         flush_i;
  logic         pc_advance_o, pc_stall_o, ibus_req_o;
  logic [W-1:0] ibus_addr_o;
  logic         ibus_gnt_i, ibus_rvalid_i;
  logic [W-1:0] ibus_rdata_i;
  logic         inst_valid_o;
  logic [W-1:0] inst_o, inst_pc_o;
  logic         inst_ready_i;

  if_fetch #(.CPU_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .jtag_reset_flag_i(jtag_reset_flag_i), .pc_i(pc_i),
    .flush_i(flush_i), .pc_advance_o(pc_advance_o), .pc_stall_o(pc_stall_o),
    .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o), .ibus_gnt_i(ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_ready_i(inst_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] addr;
    int           epoch;
    int           due;
  } bus_t;

  bus_t           bus_q[$];
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   pop_pc_q[$];
  logic [2*W-1:0] mon_e;
  logic           mon_req;
  logic [W-1:0]   model_pc, flush_tgt;
  logic           flush_req, jtag_req;
  int n_vec = 0, n_bad = 0, cyc = 0, epoch = 0, n_grants = 0;
  int gnt_pct, ready_pct, lat_min, lat_max;
  bit check_en = 1'b0;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive inputs after the edge, then update the reference model
  // from what happened in the cycle once the monitor has sampled it.
  task automatic step();
    bus_t b;
    @(posedge clk);
    #1;
    cyc++;
    pc_i              = model_pc;
    flush_i           = flush_req;
    jtag_reset_flag_i = jtag_req;
    ibus_gnt_i        = (int'($urandom_range(99, 0)) < gnt_pct);
    if (bus_q.size() > 0 && bus_q[0].due <= cyc) begin
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i  = mem_word(bus_q[0].addr);
    end else begin
      ibus_rvalid_i = 1'b0;
      ibus_rdata_i  = $urandom;
    end
    inst_ready_i = !(flush_req || jtag_req) && (int'($urandom_range(99, 0)) < ready_pct);
    @(negedge clk);
    #2;
    if (ibus_rvalid_i) begin
      b = bus_q.pop_front();
      if (!flush_i && b.epoch == epoch) exp_q.push_back({b.addr, mem_word(b.addr)});
    end
    if (pc_advance_o) n_grants++;
    if (flush_i) begin
      exp_q.delete();
      epoch++;
      model_pc = flush_tgt;
    end else if (ibus_req_o && ibus_gnt_i) begin
      bus_q.push_back('{{model_pc[W-1:2], 2'b00}, epoch,
                        cyc + int'($urandom_range(lat_max, lat_min))});
      model_pc = model_pc + 32'd4;
    end
    if (jtag_reset_flag_i) begin
      bus_q.delete();
      exp_q.delete();
      model_pc = '0;
    end
    flush_req = 1'b0;
    jtag_req  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush_i = 1'b0; jtag_reset_flag_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = '0;
    inst_ready_i = 1'b0; pc_i = '0; ibus_gnt_i = 1'b0;
    flush_req = 1'b0; jtag_req = 1'b0;
    bus_q.delete(); exp_q.delete(); pop_pc_q.delete();
    model_pc = '0; n_grants = 0;
    #1;
    chk("rst_inst_valid", inst_valid_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_inst_pc", inst_pc_o, 0);
    chk("rst_req", ibus_req_o, 1);
    chk("rst_adv_nogrant", pc_advance_o, 0);
    ibus_gnt_i = 1'b1;
    #1;
    chk("rst_adv_grant", pc_advance_o, 1);
    ibus_gnt_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: checks combinational outputs against the model and pops the
  // scoreboard whenever decode takes the head.
  always @(negedge clk) begin
    if (check_en && rst_n) begin
      mon_req = !flush_i && (bus_q.size() + exp_q.size() < DEPTH);
      chk("ibus_req", ibus_req_o, mon_req);
      chk("pc_advance", pc_advance_o, mon_req & ibus_gnt_i);
      chk("pc_stall", pc_stall_o, !(mon_req & ibus_gnt_i) && !flush_i);
      chk("ibus_addr", ibus_addr_o, {pc_i[W-1:2], 2'b00});
      chk("inst_valid", inst_valid_o, exp_q.size() != 0);
      if (inst_valid_o && inst_ready_i && exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("inst_pc", inst_pc_o, mon_e[2*W-1:W]);
        chk("inst", inst_o, mon_e[W-1:0]);
        pop_pc_q.push_back(inst_pc_o);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
    flush_tgt = '0;
    check_en = 1'b1;

    // Stream from 0x0 with single-cycle bus latency.
    do_reset();
    repeat (30) step();
    chk("stream_pops", pop_pc_q.size() >= 10, 1);
    for (int i = 0; i < 10; i++) chk("stream_pc", pop_pc_q[i], 32'(i * 4));

    // Decode stall: two grants, then requests stop with the head held at 0x0.
    do_reset();
    ready_pct = 0;
    repeat (10) step();
    chk("stall_grants", n_grants, 2);
    chk("stall_req", ibus_req_o, 0);
    chk("stall_pc_stall", pc_stall_o, 1);
    chk("stall_valid", inst_valid_o, 1);
    chk("stall_head_pc", inst_pc_o, 32'h0);
    ready_pct = 100;
    repeat (20) step();
    chk("stall_release_pops", pop_pc_q.size() >= 4, 1);
    for (int i = 0; i < 4; i++) chk("stall_release_pc", pop_pc_q[i], 32'(i * 4));

    // Flush with two requests in flight; the next visible pc is the redirect.
    do_reset();
    lat_min = 5; lat_max = 5;
    repeat (2) step();
    flush_req = 1'b1; flush_tgt = 32'h100;
    step();
    chk("flush_req_low", ibus_req_o, 0);
    chk("flush_no_stall", pc_stall_o, 0);
    lat_min = 1; lat_max = 1;
    repeat (20) step();
    chk("flush_pops", pop_pc_q.size() > 0, 1);
    chk("flush_first_pc", pop_pc_q[0], 32'h100);

    // Flush in the same cycle as a response leaves one response to discard.
    do_reset();
    lat_min = 2; lat_max = 2;
    repeat (2) step();
    flush_req = 1'b1; flush_tgt = model_pc;
    step();
    step();
    chk("flush_rv_disc_cnt", 32'(dut.disc_cnt), 1);
    lat_min = 1; lat_max = 1;
    repeat (20) step();
    chk("flush_rv_pops", pop_pc_q.size() > 0, 1);
    chk("flush_rv_first_pc", pop_pc_q[0], 32'h8);

    // Grant delay: no advance while the bus withholds the grant.
    do_reset();
    repeat (2) step();
    gnt_pct = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gdelay_adv", pc_advance_o, 0);
      chk("gdelay_addr", ibus_addr_o, 32'h8);
    end
    gnt_pct = 100;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pc_advance_o) break;
    end
    chk("gdelay_adv_on_grant", pc_advance_o, 1);
    chk("gdelay_addr_on_grant", ibus_addr_o, 32'h8);

    // JTAG reset mid-stream.
    do_reset();
    lat_min = 1; lat_max = 3;
    repeat (15) step();
    jtag_req = 1'b1;
    step();
    pop_pc_q.delete();
    step();
    chk("jtag_valid", inst_valid_o, 0);
    chk("jtag_out_cnt", 32'(dut.out_cnt), 0);
    chk("jtag_fifo_cnt", 32'(dut.fifo_cnt), 0);
    chk("jtag_req", ibus_req_o, 1);
    chk("jtag_addr", ibus_addr_o, 32'h0);
    repeat (20) step();
    chk("jtag_pops", pop_pc_q.size() > 0, 1);
    chk("jtag_first_pc", pop_pc_q[0], 32'h0);

    // Random traffic with flushes, misaligned redirects and JTAG resets.
    do_reset();
    gnt_pct = 70; ready_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99, 0) < 3) begin
        flush_req = 1'b1;
        flush_tgt = $urandom;
      end else if ($urandom_range(199, 0) == 0) begin
        jtag_req = 1'b1;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
